layer_sequencer: RTL and testbench



---
 rtl/gpu_pipe_pkg.sv | 16 +
 rtl/layer_sequencer_if.sv | 26 ++
 rtl/layer_seq_scan.sv | 32 +++
 rtl/layer_sequencer.sv | 113 +++++++++++
 tb/tb_layer_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/gpu_pipe_pkg.sv
// Shared pixel-pipeline constants and the layer sequencer state encoding.
package gpu_pipe_pkg;

  localparam int unsigned LAYER_W    = 5;
  localparam int unsigned NUM_LAYERS = 2 ** LAYER_W;
  localparam int unsigned CNT_W      = LAYER_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT,
    DONE
  } layer_seq_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Pixel start, fetch request/response and status bundle for the layer sequencer.
interface layer_sequencer_if;
  import gpu_pipe_pkg::*;

  logic                  pixelStart;
  logic [NUM_LAYERS-1:0] layerEnable;
  logic                  reqValid;
  logic                  reqReady;
  logic [LAYER_W-1:0]    reqLayer;
  logic                  respValid;
  logic                  respOpaque;
  logic                  busy;
  logic                  pixelDone;
  logic [CNT_W-1:0]      layerCount;

  modport master (
    input  pixelStart, layerEnable, reqReady, respValid, respOpaque,
    output reqValid, reqLayer, busy, pixelDone, layerCount
  );

  modport slave (
    output pixelStart, layerEnable, reqReady, respValid, respOpaque,
    input  reqValid, reqLayer, busy, pixelDone, layerCount
  );

endinterface

// File: rtl/layer_seq_scan.sv
// Layer index register with enable-mask lookup and last-layer detect.
module layer_seq_scan
  import gpu_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic [NUM_LAYERS-1:0] i_mask,
  output logic [LAYER_W-1:0]    o_layer,
  output logic                  o_hit_c,
  output logic                  o_last_c
);

  logic [LAYER_W-1:0] r_layer;

  // Index never wraps: the controller stops advancing on the last layer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_layer <= '0;
    end else if (i_clear) begin
      r_layer <= '0;
    end else if (i_advance) begin
      r_layer <= r_layer + LAYER_W'(1);
    end
  end

  assign o_layer  = r_layer;
  assign o_hit_c  = i_mask[r_layer];
  assign o_last_c = (r_layer == LAYER_W'(NUM_LAYERS - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Per-pixel layer walk controller issuing one fetch per enabled layer.
// Optional early exit on an opaque layer: LAYER_SEQ_EARLY_OPAQUE_EN.
module layer_sequencer
  import gpu_pipe_pkg::*;
(
  input logic                clk,
  input logic                reset,
  layer_sequencer_if.master  if_seq
);

  layer_seq_state_t      r_state;
  logic [NUM_LAYERS-1:0] r_mask;
  logic [CNT_W-1:0]      r_count;
  logic                  r_req_valid;
  logic                  r_busy;
  logic                  r_pixel_done;

  logic [LAYER_W-1:0]    w_layer;
  logic                  w_hit;
  logic                  w_last;
  logic                  w_clear;
  logic                  w_advance;
  logic                  w_resp_end;

`ifdef LAYER_SEQ_EARLY_OPAQUE_EN
  assign w_resp_end = w_last | if_seq.respOpaque;
`else
  logic w_unused;
  assign w_unused   = if_seq.respOpaque;
  assign w_resp_end = w_last;
`endif

  assign w_clear   = (r_state == IDLE) && if_seq.pixelStart;
  assign w_advance = ((r_state == SCAN) && !w_hit && !w_last) ||
                     ((r_state == WAIT) && if_seq.respValid && !w_resp_end);

  layer_seq_scan u_scan (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .i_mask    (r_mask),
    .o_layer   (w_layer),
    .o_hit_c   (w_hit),
    .o_last_c  (w_last)
  );

  // Outputs are registered alongside each state transition so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_count      <= '0;
      r_req_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_pixel_done <= 1'b0;
    end else begin
      r_pixel_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_seq.pixelStart) begin
            r_mask  <= if_seq.layerEnable;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_hit) begin
            r_req_valid <= 1'b1;
            r_state     <= REQ;
          end else if (w_last) begin
            r_pixel_done <= 1'b1;
            r_state      <= DONE;
          end
        end
        REQ: begin
          if (if_seq.reqReady) begin
            r_req_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (if_seq.respValid) begin
            r_count <= r_count + CNT_W'(1);
            if (w_resp_end) begin
              r_pixel_done <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_req_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign if_seq.reqValid   = r_req_valid;
  assign if_seq.reqLayer   = w_layer;
  assign if_seq.busy       = r_busy;
  assign if_seq.pixelDone  = r_pixel_done;
  assign if_seq.layerCount = r_count;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer against a request-list / cycle-budget model.
module tb_layer_sequencer;
  import gpu_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_sequencer_if u_if();

  layer_sequencer u_dut (
    .clk    (clk),
    .reset  (reset),
    .if_seq (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one pixel walk from a negedge in IDLE; ends on a negedge in IDLE.
  task automatic run_pixel(input logic [31:0] mask, input int opq,
                           input int d_min, input int d_max, input int e_max,
                           input int abort_layer, input bit spur);
    int q[$];
    int visited, exp_count, exp_cycles;
    int cyc, ph, d, e, sc, wc, cur;
    bit done, aborted;

    // Model: expected request order, serviced count and walk length in cycles
    visited = NUM_LAYERS;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (mask[i]) begin
        q.push_back(i);
`ifdef LAYER_SEQ_EARLY_OPAQUE_EN
        if (i == opq) begin
          visited = i + 1;
          break;
        end
`endif
      end
    end
    exp_count  = q.size();
    exp_cycles = visited + 1;

    cyc = 0; ph = 0; d = 0; e = 0; sc = 0; wc = 0; cur = -1;
    done = 1'b0; aborted = 1'b0;
    u_if.layerEnable = mask;
    u_if.pixelStart  = 1'b1;

    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      u_if.pixelStart = 1'b0;
      if (cyc == 1) begin
        u_if.layerEnable = $urandom;
        check("busy_after_start", 32'(u_if.busy), 1);
      end
      if (ph == 3) begin
        u_if.respValid  = 1'b0;
        u_if.respOpaque = 1'($urandom % 2);
        ph = 0;
      end
      if (ph <= 1) begin
        u_if.respValid = ($urandom % 4) == 0;
        u_if.reqReady  = 1'($urandom % 2);
      end
      if (spur && ($urandom % 8) == 0) u_if.pixelStart = 1'b1;

      if (u_if.pixelDone) begin
        check("done_cycle", cyc, exp_cycles);
        check("layer_count", 32'(u_if.layerCount), exp_count);
        check("requests_left", q.size(), 0);
        u_if.pixelStart = 1'b1;
        done = 1'b1;
      end else begin
        if (ph == 0 && u_if.reqValid) begin
          if (q.size() == 0) begin
            check("extra_request", 32'(u_if.reqLayer), 32'hFFFF_FFFF);
            done = 1'b1;
          end else begin
            cur = q.pop_front();
            check("req_layer", 32'(u_if.reqLayer), cur);
            d  = int'($urandom_range(d_max, d_min));
            sc = 0;
            exp_cycles += d + 1;
            ph = 1;
          end
        end
        if (done) begin
        end else if (ph == 1) begin
          check("req_hold", {26'd0, u_if.reqValid, u_if.reqLayer}, {26'd0, 1'b1, 5'(cur)});
          if (sc == d) begin
            u_if.reqReady = 1'b1;
            e  = int'($urandom_range(e_max, 0));
            wc = 0;
            exp_cycles += e + 1;
            ph = 2;
          end else begin
            u_if.reqReady = 1'b0;
            sc++;
          end
        end else if (ph == 2) begin
          u_if.reqReady = 1'b0;
          check("wait_no_req", 32'(u_if.reqValid), 0);
          if (cur == abort_layer) begin
            reset = 1'b1;
            u_if.respValid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            u_if.pixelStart = 1'b0;
            check("abort_busy", 32'(u_if.busy), 0);
            check("abort_reqvalid", 32'(u_if.reqValid), 0);
            check("abort_done", 32'(u_if.pixelDone), 0);
            check("abort_count", 32'(u_if.layerCount), 0);
            aborted = 1'b1;
            done    = 1'b1;
          end else if (wc == e) begin
            u_if.respValid  = 1'b1;
            u_if.respOpaque = (cur == opq);
            ph = 3;
          end else begin
            u_if.respValid = 1'b0;
            wc++;
          end
        end
      end
    end
    if (!done) check("timeout", 0, 1);

    u_if.reqReady   = 1'b0;
    u_if.respValid  = 1'b0;
    u_if.respOpaque = 1'b0;
    @(negedge clk);
    u_if.pixelStart = 1'b0;
    check("post_busy", 32'(u_if.busy), 0);
    check("post_done_low", 32'(u_if.pixelDone), 0);
    if (!aborted) check("post_count_hold", 32'(u_if.layerCount), exp_count);
    @(negedge clk);
    check("start_in_done_ignored", 32'(u_if.busy), 0);
  endtask

  initial begin
    logic [31:0] m;
    int opq;

    reset = 1'b1;
    u_if.pixelStart  = 1'b0;
    u_if.layerEnable = '1;
    u_if.reqReady    = 1'b0;
    u_if.respValid   = 1'b0;
    u_if.respOpaque  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_reqvalid", 32'(u_if.reqValid), 0);
    check("rst_done", 32'(u_if.pixelDone), 0);
    check("rst_count", 32'(u_if.layerCount), 0);
    check("rst_layer", 32'(u_if.reqLayer), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    run_pixel(32'h0000_0000, -1, 0, 0, 0, -1, 1'b0);
    run_pixel(32'h0000_0001, -1, 0, 0, 0, -1, 1'b0);
    run_pixel(32'h8000_0001, -1, 0, 0, 1, -1, 1'b1);
    run_pixel(32'h0000_0004, -1, 5, 5, 2, -1, 1'b1);
    run_pixel(32'hFFFF_FFFF, -1, 0, 1, 1, 7, 1'b0);
    run_pixel(32'hFFFF_FFFF, -1, 0, 1, 1, -1, 1'b1);
    run_pixel(32'h0000_00FF, 3, 0, 2, 2, -1, 1'b1);

    for (int n = 0; n < 24; n++) begin
      case ($urandom % 4)
        0:       m = $urandom & $urandom & $urandom;
        1:       m = $urandom;
        2:       m = $urandom | $urandom;
        default: m = 32'(1) << ($urandom % 32);
      endcase
      opq = int'($urandom_range(40, 0));
      run_pixel(m, opq, 0, 3, 3, -1, 1'b1);
      repeat ($urandom % 3) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
